// File: rtl/comp8_max_seq.sv
// Stream max/argmax through one shared COMP8 (min/argmin when COMP8_MAX_SEQ_MIN_EN is defined); result valid one cycle after the last beat.
// in_ready is high only while loading/scanning, and the result is held until out_ready; all outputs come from registers or the state decode.

module comp8 (
  input  logic [7:0] x_a,
  input  logic [7:0] x_b,
  output logic       wx
);
  assign wx = (x_a > x_b);
endmodule

module comp8_max_seq #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] len_m1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_val,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] len_q;
  logic [IDX_W:0]   cnt;
  logic [7:0]       best_val;
  logic [IDX_W-1:0] best_idx;
  logic             wx;
  logic             beat;

`ifdef COMP8_MAX_SEQ_MIN_EN
  comp8 u_comp8 (.x_a(best_val), .x_b(in_data), .wx(wx));
`else
  comp8 u_comp8 (.x_a(in_data), .x_b(best_val), .wx(wx));
`endif

  assign in_ready  = (state == LOAD) || (state == SCAN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_val   = best_val;
  assign out_idx   = best_idx;
  assign beat      = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len_m1;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (beat) begin
            best_val <= in_data;
            best_idx <= '0;
            cnt      <= (IDX_W+1)'(1);
            state    <= (len_q == '0) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (beat) begin
            // strict compare: ties keep the earlier index
            if (wx) begin
              best_val <= in_data;
              best_idx <= cnt[IDX_W-1:0];
            end
            cnt <= cnt + (IDX_W+1)'(1);
            if (cnt == {1'b0, len_q}) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp8_max_seq.sv
// Bench for comp8_max_seq: directed table, ignored-input and mid-job reset sequences, and random jobs against a queue-based model.
module tb_comp8_max_seq;
  localparam int IDX_W = 4;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int         len;
    logic [7:0] d [16];
    bit         toggle;
    int         stall;
    int         exp_lat;
    logic [7:0] ev;
    int         ei;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [IDX_W-1:0] len_m1;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_val;
  logic [IDX_W-1:0] out_idx;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  comp8_max_seq #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_m1(len_m1),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: first position holding the extreme value of the job.
  function automatic void model(input byte_q_t d, output logic [7:0] v, output int i);
    byte_q_t m;
    int ix[$];
`ifdef COMP8_MAX_SEQ_MIN_EN
    m = d.min();
`else
    m = d.max();
`endif
    v  = m[0];
    ix = d.find_first_index(x) with (x == v);
    i  = ix[0];
  endfunction

  task automatic run_job(input int len, input byte_q_t d, input bit toggle, input int stall,
                         input bit noise, output logic [7:0] rv, output int ri, output int lat);
    int k;
    int j;
    int c0;
    if (noise) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      repeat (2) begin
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_busy", busy, 0);
      end
      in_valid = 1'b0;
    end
    start  = 1'b1;
    len_m1 = len[IDX_W-1:0];
    c0     = cyc;
    @(negedge clk);
    start  = 1'b0;
    len_m1 = IDX_W'($urandom);
    k = 0;
    j = 0;
    while (k <= len && j < 200) begin
      in_valid = toggle ? ~j[0] : 1'b1;
      in_data  = in_valid ? d[k] : 8'($urandom);
      start    = noise && (k == 2);
      if (in_valid && in_ready) k++;
      @(negedge clk);
      j++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("beats_accepted", k, len + 1);
    j = 0;
    while (!out_valid && j < 100) begin
      @(negedge clk);
      j++;
    end
    chk("out_valid_seen", out_valid, 1);
    chk("in_ready_in_done", in_ready, 0);
    chk("busy_in_done", busy, 1);
    lat = cyc - c0;
    rv  = out_val;
    ri  = int'(out_idx);
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      start = noise && (s == 0);
      @(negedge clk);
      chk("hold_val", out_val, rv);
      chk("hold_idx", out_idx, ri);
      chk("hold_valid", out_valid, 1);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_busy", busy, 0);
    chk("idle_after_valid", out_valid, 0);
    @(negedge clk);
    chk("no_queued_start", busy, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t       vt [6];
    byte_q_t    q;
    logic [7:0] rv;
    logic [7:0] mv;
    int         ri;
    int         mi;
    int         lat;
    int         len;

    rst_n = 1'b0; start = 1'b0; len_m1 = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_idx", out_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vt[0] = '{len:4, d:'{0:8'h10, 1:8'h80, 2:8'h7F, 3:8'h80, 4:8'h05, default:8'h00},
              toggle:1'b0, stall:0, exp_lat:6, ev:8'h00, ei:0};
    vt[1] = '{len:0, d:'{0:8'hA5, default:8'h00}, toggle:1'b0, stall:1, exp_lat:2, ev:8'h00, ei:0};
    vt[2] = '{len:15, d:'{default:8'h00}, toggle:1'b1, stall:3, exp_lat:32, ev:8'h00, ei:0};
    for (int i = 0; i < 16; i++) vt[2].d[i] = 8'(i);
    vt[3] = '{len:3, d:'{0:8'h40, 1:8'h02, 2:8'hFF, 3:8'h02, default:8'h00},
              toggle:1'b0, stall:0, exp_lat:5, ev:8'h00, ei:0};
    vt[4] = '{len:2, d:'{0:8'h33, 1:8'h33, 2:8'h33, default:8'h00},
              toggle:1'b0, stall:1, exp_lat:4, ev:8'h00, ei:0};
    vt[5] = '{len:3, d:'{0:8'hFF, 1:8'h00, 2:8'hFF, 3:8'h01, default:8'h00},
              toggle:1'b0, stall:2, exp_lat:5, ev:8'h00, ei:0};
`ifdef COMP8_MAX_SEQ_MIN_EN
    vt[0].ev = 8'h05; vt[0].ei = 4;
    vt[1].ev = 8'hA5; vt[1].ei = 0;
    vt[2].ev = 8'h00; vt[2].ei = 0;
    vt[3].ev = 8'h02; vt[3].ei = 1;
    vt[4].ev = 8'h33; vt[4].ei = 0;
    vt[5].ev = 8'h00; vt[5].ei = 1;
`else
    vt[0].ev = 8'h80; vt[0].ei = 1;
    vt[1].ev = 8'hA5; vt[1].ei = 0;
    vt[2].ev = 8'h0F; vt[2].ei = 15;
    vt[3].ev = 8'hFF; vt[3].ei = 2;
    vt[4].ev = 8'h33; vt[4].ei = 0;
    vt[5].ev = 8'hFF; vt[5].ei = 0;
`endif

    for (int i = 0; i < 6; i++) begin
      q = {};
      for (int k = 0; k <= vt[i].len; k++) q.push_back(vt[i].d[k]);
      run_job(vt[i].len, q, vt[i].toggle, vt[i].stall, 1'b0, rv, ri, lat);
      chk($sformatf("vec%0d_val", i), rv, vt[i].ev);
      chk($sformatf("vec%0d_idx", i), ri, vt[i].ei);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
    end

    // Ignored inputs: 0xFF offered in IDLE, start pulsed in SCAN and DONE.
    q = '{8'h07, 8'h03, 8'h09, 8'h09, 8'h01};
    run_job(4, q, 1'b0, 2, 1'b1, rv, ri, lat);
    model(q, mv, mi);
    chk("noise_val", rv, mv);
    chk("noise_idx", ri, mi);
    q = '{8'h01, 8'h02, 8'h03};
    run_job(2, q, 1'b0, 0, 1'b0, rv, ri, lat);
    model(q, mv, mi);
    chk("after_noise_val", rv, mv);
    chk("after_noise_idx", ri, mi);

    // Reset two beats into an eight-element job.
    start = 1'b1; len_m1 = 4'd7;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'hC0;
    @(negedge clk);
    in_data = 8'hD0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midjob_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_val", out_val, 0);
    chk("midrst_out_idx", out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", out_valid, 0);
    q = '{8'h03, 8'h09};
    run_job(1, q, 1'b0, 0, 1'b0, rv, ri, lat);
    model(q, mv, mi);
    chk("post_rst_val", rv, mv);
    chk("post_rst_idx", ri, mi);
    chk("post_rst_latency", lat, 3);

    for (int j = 0; j < 25; j++) begin
      len = $urandom_range(0, 15);
      q = {};
      for (int k = 0; k <= len; k++)
        q.push_back(8'($urandom_range(0, (j % 2) ? 255 : 7)));
      run_job(len, q, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, rv, ri, lat);
      model(q, mv, mi);
      chk($sformatf("rand%0d_val", j), rv, mv);
      chk($sformatf("rand%0d_idx", j), ri, mi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
